// File: rtl/stepper_pkg.sv
// Shared types and coil/phase helpers for the escalator stepper sequencer.
package stepper_pkg;

  localparam int unsigned MAX_PHASES = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Coil drive pattern for a half-step position: even = one coil, odd = two adjacent coils.
  function automatic logic [MAX_PHASES-1:0] coil_pattern(input int unsigned idx,
                                                         input int unsigned phases);
    logic [MAX_PHASES-1:0] p;
    int unsigned           k;
    k = idx / 2;
    p = MAX_PHASES'(1) << k;
    if ((idx % 2) != 0) begin
      p = p | (MAX_PHASES'(1) << ((k + 1) % phases));
    end
    return p;
  endfunction

  // Next half-step position; full-step moves by 2, or by 1 to re-align an odd position.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input logic        dir,
                                           input logic        half_step,
                                           input int unsigned phases);
    int unsigned n;
    int unsigned d;
    int unsigned r;
    n = 2 * phases;
    d = (half_step || ((idx % 2) != 0)) ? 1 : 2;
    if (dir) begin
      r = idx + d;
      if (r >= n) r = r - n;
    end else begin
      r = (idx >= d) ? (idx - d) : (idx + n - d);
    end
    return r;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while run is high, tick on the last count.
module step_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = run && (count == CNT_W'(DIV - 1));

  // Counter with clear priority; wraps to 0 on tick and holds while run is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Escalator stepper sequencer: sensor-triggered fixed-length run with dir/half-step modes.
// Optional build macro HOLD_TORQUE_EN keeps the last coil pattern energised in IDLE.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned STEP_FREQ = 4,
  parameter int unsigned PHASES    = 4,
  parameter int unsigned RUN_STEPS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sensor,
  input  logic              dir,
  input  logic              half_step,
  output logic [PHASES-1:0] motor,
  output logic [PHASES-1:0] leds,
  output logic              busy,
  output logic              step_pulse
);

  localparam int unsigned DIV   = CLK_FREQ / STEP_FREQ;
  localparam int unsigned IDX_W = $clog2(2 * PHASES);
  localparam int unsigned REM_W = (RUN_STEPS > 1) ? $clog2(RUN_STEPS + 1) : 1;

  logic             sync1, sync2, sync3;
  logic             accept, run, tick;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [PHASES-1:0] pattern, motor_d;
  logic             step_d;

  assign accept  = sync2 && !sync3 && enable;
  assign run     = (state_q == RUN) && enable;
  assign pattern = PHASES'(coil_pattern(32'(idx_q), PHASES));

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (accept),
    .tick  (tick)
  );

  // Two-flop sensor synchroniser plus one delayed copy for rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Next-state, step bookkeeping and coil output selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    step_d  = 1'b0;
    motor_d = '0;
    case (state_q)
      IDLE: begin
`ifdef HOLD_TORQUE_EN
        if (enable) motor_d = pattern;
`endif
        if (accept) begin
          state_d = RUN;
          rem_d   = REM_W'(RUN_STEPS);
        end
      end
      RUN: begin
        if (enable) motor_d = pattern;
        if (tick) begin
          idx_d  = IDX_W'(next_idx(32'(idx_q), dir, half_step, PHASES));
          step_d = 1'b1;
          rem_d  = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
        // Retrigger reloads the run length and wins over the final-step exit.
        if (accept) begin
          rem_d   = REM_W'(RUN_STEPS);
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, position and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rem_q      <= '0;
      motor      <= '0;
      leds       <= '0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      motor      <= motor_d;
      leds       <= motor_d;
      busy       <= (state_d == RUN);
      step_pulse <= step_d;
    end
  end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Self-checking bench for stepper_seq_ctrl: directed scenarios then random stimulus vs. a reference model.
module tb_stepper_seq_ctrl;

  localparam int unsigned CLK_FREQ  = 40;
  localparam int unsigned STEP_FREQ = 4;
  localparam int unsigned PHASES    = 4;
  localparam int unsigned RUN_STEPS = 4;
  localparam int          DIV       = CLK_FREQ / STEP_FREQ;
  localparam int          NPOS      = 2 * PHASES;
`ifdef HOLD_TORQUE_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              sensor = 1'b0;
  logic              dir = 1'b1;
  logic              half_step = 1'b0;
  logic [PHASES-1:0] motor, leds;
  logic              busy, step_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int seen_steps = 0;

  // Reference model state
  logic [2:0] m_hist;
  bit         m_run;
  int         m_pos, m_left, m_wait;
  int         exp_motor, exp_busy, exp_step;

  stepper_seq_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .STEP_FREQ (STEP_FREQ),
    .PHASES    (PHASES),
    .RUN_STEPS (RUN_STEPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sensor     (sensor),
    .dir        (dir),
    .half_step  (half_step),
    .motor      (motor),
    .leds       (leds),
    .busy       (busy),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Coils lit for a half-step position, as a bit mask.
  function automatic int coils_for(input int pos);
    int v = 0;
    for (int c = 0; c < PHASES; c++) begin
      if (c == pos / 2 || ((pos % 2) == 1 && c == (pos / 2 + 1) % PHASES)) v |= (1 << c);
    end
    return v;
  endfunction

  // Predict outputs after the coming clock edge from the inputs currently applied.
  task automatic model_update();
    bit was_run, trig, stepped;
    int was_pos, delta;
    if (rst) begin
      m_hist = '0; m_run = 0; m_pos = 0; m_left = 0; m_wait = DIV;
      exp_motor = 0; exp_busy = 0; exp_step = 0;
      return;
    end
    was_run = m_run;
    was_pos = m_pos;
    trig    = m_hist[1] && !m_hist[2];
    m_hist  = {m_hist[1:0], sensor};
    stepped = 0;
    if (was_run && enable) begin
      m_wait--;
      if (m_wait == 0) begin
        stepped = 1;
        m_wait  = DIV;
        delta   = (half_step || (m_pos % 2) == 1) ? 1 : 2;
        m_pos   = (m_pos + (dir ? delta : NPOS - delta)) % NPOS;
        m_left--;
        if (m_left == 0) m_run = 0;
      end
    end
    if (trig && enable) begin
      m_run  = 1;
      m_left = RUN_STEPS;
      m_wait = DIV;
    end
    exp_motor = (enable && (was_run || HOLD)) ? coils_for(was_pos) : 0;
    exp_busy  = m_run;
    exp_step  = stepped;
  endtask

  // One clock: update model, then compare on the falling edge.
  task automatic cycle();
    model_update();
    @(negedge clk);
    check("motor", int'(motor), exp_motor);
    check("leds", int'(leds), exp_motor);
    check("busy", int'(busy), exp_busy);
    check("step_pulse", int'(step_pulse), exp_step);
    if (step_pulse) seen_steps++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse(input int hi);
    sensor = 1'b1;
    run_cycles(hi);
    sensor = 1'b0;
  endtask

  initial begin
    // Reset, then idle with sensor low
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    enable = 1'b1;
    seen_steps = 0;
    run_cycles(50);
    check("idle_no_steps", seen_steps, 0);

    // Forward full-step run
    dir = 1'b1; half_step = 1'b0;
    seen_steps = 0;
    pulse(3);
    run_cycles(60);
    check("run_len_fwd", seen_steps, RUN_STEPS);

    // Reverse half-step run
    dir = 1'b0; half_step = 1'b1;
    seen_steps = 0;
    pulse(3);
    run_cycles(60);
    check("run_len_rev", seen_steps, RUN_STEPS);

    // Retrigger landing on the third tick
    dir = 1'b1; half_step = 1'b0;
    seen_steps = 0;
    pulse(3);
    for (int i = 0; i < 200 && seen_steps < 2; i++) cycle();
    check("wait_step2", seen_steps, 2);
    run_cycles(7);
    pulse(3);
    run_cycles(100);
    check("retrig_steps", seen_steps, 7);

    // Enable gap mid-run
    seen_steps = 0;
    pulse(3);
    run_cycles(25);
    enable = 1'b0;
    run_cycles(25);
    enable = 1'b1;
    run_cycles(60);
    check("gap_steps", seen_steps, RUN_STEPS);

    // Switch to full-step from an odd half-step position
    dir = 1'b1; half_step = 1'b1;
    pulse(3);
    run_cycles(15);
    half_step = 1'b0;
    run_cycles(60);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) sensor = ~sensor;
      if (enable) begin
        if ($urandom_range(0, 49) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) half_step = ~half_step;
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
